// File: rtl/l2_cache_wb.sv
// l2_cache_wb: N-way set-associative write-back/write-allocate L2 cache
// with true-LRU replacement, dirty-victim writeback and whole-cache flush.
module l2_cache_wb #(
    parameter int DATA_WIDTH  = 32,
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_WIDTH  = 11,
    parameter int NUM_SETS    = 16,
    parameter int NUM_WAYS    = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              l1_req_valid,
    input  logic                              l1_req_write,
    input  logic [ADDR_WIDTH-1:0]             l1_req_addr,
    input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] l1_req_data,
    output logic                              l1_req_ready,
    output logic                              l1_resp_valid,
    output logic                              l1_resp_hit,
    output logic [BLOCK_WORDS*DATA_WIDTH-1:0] l1_resp_data,
    input  logic                              flush_req,
    output logic                              flush_done,
    output logic                              mem_read,
    output logic                              mem_write,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [BLOCK_WORDS*DATA_WIDTH-1:0] mem_data_out,
    input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] mem_data_block,
    input  logic                              mem_ready
);
    localparam int BLK_W  = BLOCK_WORDS * DATA_WIDTH;
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int WAY_W  = $clog2(NUM_WAYS);
    localparam int TAG_W  = ADDR_WIDTH - IDX_W;
    localparam int SCAN_W = IDX_W + WAY_W;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, WRITEBACK, FILL, RESPOND, FLUSH_SCAN, FLUSH_WB
    } state_e;

    state_e              state_q, state_d;
    logic                req_write_q, req_write_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [BLK_W-1:0]    req_data_q, req_data_d;
    logic [WAY_W-1:0]    victim_q, victim_d;
    logic                hit_q, hit_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_hit_q, resp_hit_d;
    logic [BLK_W-1:0]    resp_data_q, resp_data_d;
    logic                flush_done_q, flush_done_d;
    logic [SCAN_W-1:0]   scan_q, scan_d;

    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_d [NUM_SETS];
    logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]    tag_d   [NUM_SETS][NUM_WAYS];
    logic [BLK_W-1:0]    data_q  [NUM_SETS][NUM_WAYS];
    logic [BLK_W-1:0]    data_d  [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]    age_q   [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]    age_d   [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]    age_rst [NUM_SETS][NUM_WAYS];

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    scan_set;
    logic [WAY_W-1:0]    scan_way;
    logic                hit_any, inv_any;
    logic [WAY_W-1:0]    hit_way, inv_way, lru_way, victim_way;
    logic                inst, inst_dirty, touch;
    logic [WAY_W-1:0]    tgt_way;
    logic [BLK_W-1:0]    inst_data;

    assign idx      = req_addr_q[IDX_W-1:0];
    assign req_tag  = req_addr_q[ADDR_WIDTH-1:IDX_W];
    assign scan_set = scan_q[WAY_W +: IDX_W];
    assign scan_way = scan_q[WAY_W-1:0];

    always_comb begin
        for (int s = 0; s < NUM_SETS; s++) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                age_rst[s][w] = WAY_W'(w);
            end
        end
    end

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        lru_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == req_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (age_q[idx][w] == WAY_W'(NUM_WAYS - 1)) begin
                lru_way = WAY_W'(w);
            end
        end
        // Descending walk leaves the lowest-index invalid way selected
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    assign victim_way = inv_any ? inv_way : lru_way;

    always_comb begin
        state_d      = state_q;
        req_write_d  = req_write_q;
        req_addr_d   = req_addr_q;
        req_data_d   = req_data_q;
        victim_d     = victim_q;
        hit_d        = hit_q;
        resp_data_d  = resp_data_q;
        scan_d       = scan_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        tag_d        = tag_q;
        data_d       = data_q;
        age_d        = age_q;
        inst         = 1'b0;
        inst_dirty   = 1'b0;
        inst_data    = req_data_q;
        touch        = 1'b0;
        tgt_way      = victim_q;
        resp_valid_d = (state_q == RESPOND);
        resp_hit_d   = (state_q == RESPOND) && hit_q;
        flush_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    scan_d  = '0;
                    state_d = FLUSH_SCAN;
                end else if (l1_req_valid) begin
                    req_write_d = l1_req_write;
                    req_addr_d  = l1_req_addr;
                    req_data_d  = l1_req_data;
                    state_d     = LOOKUP;
                end
            end
            LOOKUP: begin
                hit_d = hit_any;
                if (hit_any) begin
                    tgt_way    = hit_way;
                    victim_d   = hit_way;
                    touch      = 1'b1;
                    inst       = req_write_q;
                    inst_dirty = 1'b1;
                    if (!req_write_q) begin
                        resp_data_d = data_q[idx][hit_way];
                    end
                    state_d = RESPOND;
                end else begin
                    tgt_way  = victim_way;
                    victim_d = victim_way;
                    if (valid_q[idx][victim_way] && dirty_q[idx][victim_way]) begin
                        state_d = WRITEBACK;
                    end else if (req_write_q) begin
                        inst       = 1'b1;
                        inst_dirty = 1'b1;
                        touch      = 1'b1;
                        state_d    = RESPOND;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            WRITEBACK: begin
                if (mem_ready) begin
                    if (req_write_q) begin
                        inst       = 1'b1;
                        inst_dirty = 1'b1;
                        touch      = 1'b1;
                        state_d    = RESPOND;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (mem_ready) begin
                    inst        = 1'b1;
                    inst_data   = mem_data_block;
                    resp_data_d = mem_data_block;
                    touch       = 1'b1;
                    state_d     = RESPOND;
                end
            end
            RESPOND: state_d = IDLE;
            FLUSH_SCAN: begin
                if (valid_q[scan_set][scan_way] && dirty_q[scan_set][scan_way]) begin
                    state_d = FLUSH_WB;
                end else if (&scan_q) begin
                    flush_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    scan_d = scan_q + 1'b1;
                end
            end
            FLUSH_WB: begin
                if (mem_ready) begin
                    dirty_d[scan_set][scan_way] = 1'b0;
                    state_d = FLUSH_SCAN;
                end
            end
            default: state_d = IDLE;
        endcase

        if (inst) begin
            valid_d[idx][tgt_way] = 1'b1;
            dirty_d[idx][tgt_way] = inst_dirty;
            tag_d[idx][tgt_way]   = req_tag;
            data_d[idx][tgt_way]  = inst_data;
        end
        // Ages younger than the accessed line shift up by one
        if (touch) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (WAY_W'(w) == tgt_way) begin
                    age_d[idx][w] = '0;
                end else if (age_q[idx][w] < age_q[idx][tgt_way]) begin
                    age_d[idx][w] = age_q[idx][w] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_write_q  <= 1'b0;
            req_addr_q   <= '0;
            req_data_q   <= '0;
            victim_q     <= '0;
            hit_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_data_q  <= '0;
            flush_done_q <= 1'b0;
            scan_q       <= '0;
            valid_q      <= '{default: '0};
            dirty_q      <= '{default: '0};
            age_q        <= age_rst;
        end else begin
            state_q      <= state_d;
            req_write_q  <= req_write_d;
            req_addr_q   <= req_addr_d;
            req_data_q   <= req_data_d;
            victim_q     <= victim_d;
            hit_q        <= hit_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_data_q  <= resp_data_d;
            flush_done_q <= flush_done_d;
            scan_q       <= scan_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            age_q        <= age_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    always_comb begin
        mem_addr     = '0;
        mem_data_out = '0;
        case (state_q)
            WRITEBACK: begin
                mem_addr     = {tag_q[idx][victim_q], idx};
                mem_data_out = data_q[idx][victim_q];
            end
            FILL: mem_addr = req_addr_q;
            FLUSH_WB: begin
                mem_addr     = {tag_q[scan_set][scan_way], scan_set};
                mem_data_out = data_q[scan_set][scan_way];
            end
            default: ;
        endcase
    end

    assign mem_read      = (state_q == FILL);
    assign mem_write     = (state_q == WRITEBACK) || (state_q == FLUSH_WB);
    assign l1_req_ready  = !rst && (state_q == IDLE) && !flush_req;
    assign l1_resp_valid = resp_valid_q;
    assign l1_resp_hit   = resp_hit_q;
    assign l1_resp_data  = resp_data_q;
    assign flush_done    = flush_done_q;

endmodule

// File: tb/tb_l2_cache_wb.sv
// Directed bench for l2_cache_wb: misses, hits, evictions, flush and
// reset during writeback, against a latency-configurable memory model.
module tb_l2_cache_wb;
    localparam int AW = 11;
    localparam int BW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          l1_req_valid, l1_req_write;
    logic [AW-1:0] l1_req_addr;
    logic [BW-1:0] l1_req_data;
    logic          l1_req_ready, l1_resp_valid, l1_resp_hit;
    logic [BW-1:0] l1_resp_data;
    logic          flush_req, flush_done;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_data_out, mem_data_block;
    logic          mem_ready = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    logic [AW:0]   ev[$];
    logic [BW-1:0] wr_dat[$];
    int  mem_lat  = 3;
    bit  hold_mem = 1'b0;
    int  wcnt     = 0;
    bit  both_seen = 1'b0;
    logic rdy_busy;

    l2_cache_wb dut (
        .clk(clk), .rst(rst),
        .l1_req_valid(l1_req_valid), .l1_req_write(l1_req_write),
        .l1_req_addr(l1_req_addr), .l1_req_data(l1_req_data),
        .l1_req_ready(l1_req_ready), .l1_resp_valid(l1_resp_valid),
        .l1_resp_hit(l1_resp_hit), .l1_resp_data(l1_resp_data),
        .flush_req(flush_req), .flush_done(flush_done),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_data_out(mem_data_out),
        .mem_data_block(mem_data_block), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] blk(input logic [31:0] b);
        logic [BW-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = b ^ 32'(i);
        return r;
    endfunction

    // Fill data: word i = 0xDEADBEEF ^ i for block 0x00A, other blocks differ
    function automatic logic [BW-1:0] fill_blk(input logic [AW-1:0] a);
        return blk(32'hDEADBEEF ^ {a ^ 11'h00A, 21'h0});
    endfunction

    assign mem_data_block = fill_blk(mem_addr);

    always @(negedge clk) begin
        if (mem_read && mem_write) both_seen = 1'b1;
        if (rst || hold_mem || !(mem_read || mem_write)) begin
            mem_ready = 1'b0;
            wcnt = 0;
        end else if (wcnt >= mem_lat - 1) begin
            mem_ready = 1'b1;
            wcnt = 0;
            ev.push_back({mem_write, mem_addr});
            if (mem_write) wr_dat.push_back(mem_data_out);
        end else begin
            mem_ready = 1'b0;
            wcnt++;
        end
    end

    task automatic chk(input string tag, input logic [BW-1:0] obs,
                       input logic [BW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic wr, input logic [AW-1:0] a,
                          input logic [31:0] base, output int lat,
                          output logic hit, output logic [BW-1:0] rd);
        int g = 0;
        while (!l1_req_ready && g < 100) begin
            @(posedge clk); #1; g++;
        end
        l1_req_valid = 1'b1;
        l1_req_write = wr;
        l1_req_addr  = a;
        l1_req_data  = blk(base);
        @(posedge clk); #1;
        l1_req_valid = 1'b0;
        rdy_busy = l1_req_ready;
        lat = 0;
        while (!l1_resp_valid && lat < 300) begin
            @(posedge clk); #1; lat++;
        end
        chk("resp_valid", 256'(l1_resp_valid), 256'(1'b1));
        hit = l1_resp_hit;
        rd  = l1_resp_data;
    endtask

    task automatic do_flush(output int cnt, output bit saw_resp);
        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        chk("ready_in_flush", 256'(l1_req_ready), 256'(1'b0));
        cnt = 0;
        saw_resp = 1'b0;
        while (!flush_done && cnt < 2000) begin
            @(posedge clk); #1; cnt++;
            if (l1_resp_valid) saw_resp = 1'b1;
        end
        chk("flush_done", 256'(flush_done), 256'(1'b1));
    endtask

    initial begin
        int lat;
        int cnt;
        bit saw;
        logic hit;
        logic [BW-1:0] d;

        rst = 1'b1;
        l1_req_valid = 1'b0;
        l1_req_write = 1'b0;
        l1_req_addr  = '0;
        l1_req_data  = '0;
        flush_req    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 256'(l1_req_ready), 256'(1'b0));
        chk("rst_mem_rd", 256'(mem_read), 256'(1'b0));
        chk("rst_mem_wr", 256'(mem_write), 256'(1'b0));
        chk("rst_resp_valid", 256'(l1_resp_valid), 256'(1'b0));
        chk("rst_resp_data", l1_resp_data, '0);
        chk("rst_mem_addr", 256'(mem_addr), '0);
        chk("rst_mem_dout", mem_data_out, '0);
        chk("rst_flush_done", 256'(flush_done), 256'(1'b0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", 256'(l1_req_ready), 256'(1'b1));

        // Read miss then hit
        do_req(1'b0, 11'h00A, 32'h0, lat, hit, d);
        chk("s1_miss_hit", 256'(hit), 256'(1'b0));
        chk("s1_busy_ready", 256'(rdy_busy), 256'(1'b0));
        chk("s1_word0", 256'(d[31:0]), 256'(32'hDEADBEEF));
        chk("s1_word7", 256'(d[255:224]), 256'(32'hDEADBEE8));
        chk("s1_ev_n", 256'(ev.size()), 256'(1));
        chk("s1_ev0", 256'(ev[0]), 256'({1'b0, 11'h00A}));
        ev.delete();
        do_req(1'b0, 11'h00A, 32'h0, lat, hit, d);
        chk("s1_hit", 256'(hit), 256'(1'b1));
        chk("s1_hit_lat", 256'(lat), 256'(2));
        chk("s1_hit_word0", 256'(d[31:0]), 256'(32'hDEADBEEF));
        chk("s1_hit_ev_n", 256'(ev.size()), 256'(0));

        // Write miss, installed without a fetch
        do_req(1'b1, 11'h014, 32'hA5A5A5A5, lat, hit, d);
        chk("s2_wmiss_hit", 256'(hit), 256'(1'b0));
        chk("s2_ev_n", 256'(ev.size()), 256'(0));
        do_req(1'b0, 11'h014, 32'h0, lat, hit, d);
        chk("s2_rhit", 256'(hit), 256'(1'b1));
        chk("s2_word3", 256'(d[127:96]), 256'(32'hA5A5A5A6));

        // Dirty eviction of 0x01A
        do_req(1'b0, 11'h00A, 32'h0, lat, hit, d);
        chk("s3_hit_a", 256'(hit), 256'(1'b1));
        do_req(1'b1, 11'h01A, 32'h1000001A, lat, hit, d);
        do_req(1'b1, 11'h02A, 32'h1000002A, lat, hit, d);
        do_req(1'b1, 11'h03A, 32'h1000003A, lat, hit, d);
        chk("s3_wmiss_hit", 256'(hit), 256'(1'b0));
        do_req(1'b0, 11'h00A, 32'h0, lat, hit, d);
        chk("s3_hit_b", 256'(hit), 256'(1'b1));
        chk("s3_pre_ev_n", 256'(ev.size()), 256'(0));
        do_req(1'b0, 11'h04A, 32'h0, lat, hit, d);
        chk("s3_miss_hit", 256'(hit), 256'(1'b0));
        chk("s3_ev_n", 256'(ev.size()), 256'(2));
        chk("s3_ev0_wb", 256'(ev[0]), 256'({1'b1, 11'h01A}));
        chk("s3_ev1_rd", 256'(ev[1]), 256'({1'b0, 11'h04A}));
        chk("s3_wb_data", wr_dat[0], blk(32'h1000001A));
        chk("s3_fill_data", d, fill_blk(11'h04A));
        ev.delete();
        wr_dat.delete();

        // Clean eviction in set 5
        do_req(1'b0, 11'h005, 32'h0, lat, hit, d);
        do_req(1'b0, 11'h015, 32'h0, lat, hit, d);
        do_req(1'b0, 11'h025, 32'h0, lat, hit, d);
        do_req(1'b0, 11'h035, 32'h0, lat, hit, d);
        ev.delete();
        do_req(1'b0, 11'h045, 32'h0, lat, hit, d);
        chk("s4_miss_hit", 256'(hit), 256'(1'b0));
        chk("s4_ev_n", 256'(ev.size()), 256'(1));
        chk("s4_ev0", 256'(ev[0]), 256'({1'b0, 11'h045}));
        do_req(1'b0, 11'h005, 32'h0, lat, hit, d);
        chk("s4_victim_gone", 256'(hit), 256'(1'b0));
        do_req(1'b0, 11'h025, 32'h0, lat, hit, d);
        chk("s4_keep_025", 256'(hit), 256'(1'b1));
        ev.delete();
        wr_dat.delete();

        // Flush wins over a simultaneous request
        l1_req_valid = 1'b1;
        l1_req_write = 1'b0;
        l1_req_addr  = 11'h00A;
        flush_req    = 1'b1;
        #1;
        chk("flush_prio_ready", 256'(l1_req_ready), 256'(1'b0));
        @(posedge clk); #1;
        l1_req_valid = 1'b0;
        flush_req    = 1'b0;
        cnt = 0;
        saw = 1'b0;
        while (!flush_done && cnt < 2000) begin
            @(posedge clk); #1; cnt++;
            if (l1_resp_valid) saw = 1'b1;
        end
        chk("s5_done", 256'(flush_done), 256'(1'b1));
        chk("s5_no_resp", 256'(saw), 256'(1'b0));
        chk("s5_ev_n", 256'(ev.size()), 256'(3));
        chk("s5_ev0", 256'(ev[0]), 256'({1'b1, 11'h014}));
        chk("s5_ev1", 256'(ev[1]), 256'({1'b1, 11'h02A}));
        chk("s5_ev2", 256'(ev[2]), 256'({1'b1, 11'h03A}));
        chk("s5_dat0", wr_dat[0], blk(32'hA5A5A5A5));
        chk("s5_dat2", wr_dat[2], blk(32'h1000003A));
        @(posedge clk); #1;
        chk("s5_done_pulse", 256'(flush_done), 256'(1'b0));
        ev.delete();
        wr_dat.delete();
        do_flush(cnt, saw);
        chk("s5_clean_cycles", 256'(cnt), 256'(64));
        chk("s5_clean_ev_n", 256'(ev.size()), 256'(0));

        // Reset while a dirty victim is being written back
        do_req(1'b1, 11'h007, 32'h10000007, lat, hit, d);
        do_req(1'b1, 11'h017, 32'h10000017, lat, hit, d);
        do_req(1'b1, 11'h027, 32'h10000027, lat, hit, d);
        do_req(1'b1, 11'h037, 32'h10000037, lat, hit, d);
        hold_mem = 1'b1;
        l1_req_valid = 1'b1;
        l1_req_write = 1'b0;
        l1_req_addr  = 11'h047;
        @(posedge clk); #1;
        l1_req_valid = 1'b0;
        cnt = 0;
        while (!mem_write && cnt < 50) begin
            @(posedge clk); #1; cnt++;
        end
        chk("s6_wb_active", 256'(mem_write), 256'(1'b1));
        chk("s6_wb_addr", 256'(mem_addr), 256'(11'h007));
        chk("s6_wb_data", mem_data_out, blk(32'h10000007));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("s6_wr_drop", 256'(mem_write), 256'(1'b0));
        chk("s6_rd_low", 256'(mem_read), 256'(1'b0));
        @(posedge clk); #1;
        rst = 1'b0;
        hold_mem = 1'b0;
        ev.delete();
        wr_dat.delete();
        do_req(1'b0, 11'h00A, 32'h0, lat, hit, d);
        chk("s6_post_miss", 256'(hit), 256'(1'b0));
        chk("s6_post_ev_n", 256'(ev.size()), 256'(1));
        chk("s6_post_ev0", 256'(ev[0]), 256'({1'b0, 11'h00A}));
        chk("never_rd_and_wr", 256'(both_seen), 256'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
